// File: rtl/loader_ahb_master.sv
`default_nettype none
// ============================================================================
// Module   : loader_ahb_master
// Brief    : Packs a byte stream into little-endian 32-bit words and writes
//            them to consecutive word addresses as single AHB-Lite transfers.
// Revision : 1.0 - initial release
// ============================================================================
module loader_ahb_master #(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY
);

    localparam logic [1:0]       c_trans_idle   = 2'b00;
    localparam logic [1:0]       c_trans_nonseq = 2'b10;
    localparam logic [2:0]       c_hsize_word   = 3'b010;
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
    localparam logic [31:0]      c_word_mask    = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ADDR    = 3'd2,
        S_DATA    = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_addr;
    logic [31:0]        r_haddr;
    logic [31:0]        r_word;
    logic [31:0]        r_hwdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_idx;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rx_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        HTRANS      = c_trans_idle;
        HWRITE      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (word_cnt == '0) ? S_FIN : S_COLLECT;
                end
            end
            S_COLLECT: begin
                rx_ready = 1'b1;
                if (rx_valid && (r_idx == 2'd3)) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                HTRANS = c_trans_nonseq;
                HWRITE = 1'b1;
                if (HREADY) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    w_state_nxt = (r_cnt == c_cnt_one) ? S_FIN : S_COLLECT;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // HADDR/HWDATA are separate registers so they keep the last driven value
    // while the running address and the word being packed move on.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr   <= '0;
            r_haddr  <= '0;
            r_word   <= '0;
            r_hwdata <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (word_cnt != '0)) begin
                        r_addr <= base_addr & c_word_mask;
                        r_cnt  <= word_cnt;
                        r_idx  <= '0;
                    end
                end
                S_COLLECT: begin
                    if (rx_valid) begin
                        r_word[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_idx                        <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_haddr <= r_addr;
                        end
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        r_hwdata <= r_word;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        r_cnt  <= r_cnt - c_cnt_one;
                        r_addr <= r_addr + 32'd4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign HADDR  = r_haddr;
    assign HWDATA = r_hwdata;
    assign HSIZE  = c_hsize_word;

endmodule
`default_nettype wire

// File: tb/tb_loader_ahb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_loader_ahb_master
// Brief    : Directed/randomized bench for loader_ahb_master with a bus monitor
//            and a word-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loader_ahb_master;

    localparam int CNT_W = 16;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_cnt;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             busy;
    logic             done;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [31:0]      HWDATA;
    logic             HREADY = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int aw_waits = 0;
    int dw_waits = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_dcyc = 0;

    always #5 HCLK = ~HCLK;

    loader_ahb_master #(.CNT_W(CNT_W)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .start    (start),
        .base_addr(base_addr),
        .word_cnt (word_cnt),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .done     (done),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus monitor and wait-state slave: observes at the falling edge,
    // drives HREADY just after the rising edge.
    logic        dph = 1'b0, nx_dph = 1'b0, held_a = 1'b0, held_d = 1'b0;
    logic [31:0] last_a = '0, last_d = '0;
    int          wcnt = 0;

    always begin
        @(negedge HCLK);
        cyc++;
        if (!HRESETn) begin
            dph = 0; nx_dph = 0; held_a = 0; held_d = 0; wcnt = 0;
        end else begin
            if (held_a) begin
                chk("addr_hold_htrans", 32'(HTRANS), 32'h2);
                chk("addr_hold_haddr", HADDR, last_a);
            end
            if (dph && held_d) chk("data_hold_hwdata", HWDATA, last_d);
            if (dph) begin
                if (HREADY) begin
                    obs_data.push_back(HWDATA);
                    last_dcyc = cyc;
                    held_d = 0;
                end else begin
                    held_d = 1;
                    last_d = HWDATA;
                end
            end
            held_a = 0;
            if (HTRANS == 2'b10) begin
                chk("addr_hwrite", 32'(HWRITE), 32'h1);
                chk("addr_hsize", 32'(HSIZE), 32'h2);
                if (HREADY) begin
                    obs_addr.push_back(HADDR);
                end else begin
                    held_a = 1;
                    last_a = HADDR;
                end
            end
            nx_dph = (HTRANS == 2'b10 && HREADY) || (dph && !HREADY);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        @(posedge HCLK);
        #1;
        dph = nx_dph;
        if (HTRANS == 2'b10) begin
            if (wcnt < aw_waits) begin HREADY = 1'b0; wcnt++; end
            else begin HREADY = 1'b1; wcnt = 0; end
        end else if (dph) begin
            if (wcnt < dw_waits) begin HREADY = 1'b0; wcnt++; end
            else begin HREADY = 1'b1; wcnt = 0; end
        end else begin
            HREADY = 1'b1;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'h0);
        chk({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
        chk({tag, "_haddr"}, HADDR, 32'h0);
        chk({tag, "_hwdata"}, HWDATA, 32'h0);
        chk({tag, "_hsize"}, 32'(HSIZE), 32'h2);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h0);
    endtask

    task automatic do_start(input logic [31:0] base, input int cnt);
        start     = 1'b1;
        base_addr = base;
        word_cnt  = CNT_W'(cnt);
        @(posedge HCLK); #1;
        start     = 1'b0;
        base_addr = $urandom;
        word_cnt  = CNT_W'($urandom);
        chk("busy_after_start", 32'(busy), 32'h1);
        if (cnt == 0) begin
            chk("zero_cnt_done", 32'(done), 32'h1);
        end else begin
            // a second request while busy must be ignored
            start = 1'b1;
            @(posedge HCLK); #1;
            start = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int  n;
        int  t;
        bit  acc;
        n = $urandom_range(0, maxgap);
        if (n > 0) begin
            rx_valid = 1'b0;
            repeat (n) begin @(posedge HCLK); #1; end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc = 0;
        t   = 0;
        while (!acc && t < 100) begin
            @(negedge HCLK);
            acc = rx_ready;
            @(posedge HCLK); #1;
            t++;
        end
        if (!acc) chk("rx_accept_timeout", 32'(acc), 32'h1);
    endtask

    task automatic run_load(input logic [31:0] base, input int cnt, input int maxgap,
                            input int stop_after, input bit use_fixed,
                            input logic [31:0] fixed_w);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        logic [31:0] w;
        int          nb;
        int          t;
        bit          aborted;
        obs_addr.delete();
        obs_data.delete();
        done_cnt = 0;
        nb       = 0;
        aborted  = 0;
        for (int i = 0; i < cnt; i++) begin
            exp_a.push_back((base & 32'hFFFF_FFFC) + 32'(4 * i));
            w = (use_fixed && i == 0) ? fixed_w : $urandom;
            exp_d.push_back(w);
        end
        do_start(base, cnt);
        for (int i = 0; i < cnt; i++) begin
            w = exp_d[i];
            for (int k = 0; k < 4; k++) begin
                if (nb == stop_after) aborted = 1;
                if (!aborted) begin
                    send_byte(w[8*k +: 8], maxgap);
                    nb++;
                end
            end
        end
        if (aborted) return;
        // keep offering a byte outside COLLECT; it must not be consumed
        rx_data = 8'hA5;
        t = 0;
        while (done_cnt == 0 && t < 200) begin @(posedge HCLK); #1; t++; end
        rx_valid = 1'b0;
        repeat (3) begin @(posedge HCLK); #1; end
        chk("done_count", done_cnt, 1);
        chk("busy_after_done", 32'(busy), 32'h0);
        chk("n_addr_phases", obs_addr.size(), cnt);
        chk("n_data_phases", obs_data.size(), cnt);
        for (int i = 0; i < cnt && i < obs_addr.size() && i < obs_data.size(); i++) begin
            chk("write_addr", obs_addr[i], exp_a[i]);
            chk("write_data", obs_data[i], exp_d[i]);
        end
        if (cnt > 0) begin
            chk("haddr_holds", HADDR, exp_a[cnt-1]);
            chk("hwdata_holds", HWDATA, exp_d[cnt-1]);
        end
    endtask

    initial begin
        logic [31:0] rbase;
        HRESETn   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        word_cnt  = '0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check_reset_outputs("por");
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // single word, zero wait states, fixed bytes 78 56 34 12
        aw_waits = 0; dw_waits = 0;
        run_load(32'h0000_0100, 1, 0, -1, 1'b1, 32'h1234_5678);
        chk("done_after_data", done_cyc, last_dcyc + 1);

        // three words with slave wait states
        aw_waits = 2; dw_waits = 1;
        run_load(32'h0000_0000, 3, 0, -1, 1'b0, '0);

        // zero count, then misaligned base
        aw_waits = 0; dw_waits = 0;
        run_load(32'h0000_0203, 0, 0, -1, 1'b0, '0);
        run_load(32'h0000_0203, 1, 0, -1, 1'b0, '0);

        // random data with rx_valid gaps and random wait states
        aw_waits = $urandom_range(0, 2); dw_waits = $urandom_range(0, 2);
        run_load($urandom, 4, 3, -1, 1'b0, '0);

        // address wrap
        aw_waits = 0; dw_waits = 1;
        run_load(32'hFFFF_FFFC, 2, 1, -1, 1'b0, '0);

        // reset after two bytes of the second word
        aw_waits = 1; dw_waits = 0;
        rbase = $urandom;
        run_load(rbase, 3, 1, 6, 1'b0, '0);
        #3;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        chk("pre_reset_writes", obs_addr.size(), 1);
        if (obs_addr.size() > 0) chk("pre_reset_addr", obs_addr[0], rbase & 32'hFFFF_FFFC);
        rx_valid = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk("no_done_on_reset", done_cnt, 0);
        run_load(32'h0000_1000, 2, 1, -1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
